// File: rtl/uart_cfg_core.sv
// Parametrised full-duplex UART: TX engine with valid/ready handshake and RX engine
// with a single holding register plus parity, framing and overrun status.
`timescale 1ns/1ps
module uart_cfg_core #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam bit HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- TX engine ----------------
  state_t                tx_state, tx_state_n;
  logic [CNT_W-1:0]      tx_cnt, tx_cnt_n;
  logic [IDX_W-1:0]      tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0]  tx_sh, tx_sh_n;
  logic                  tx_par, tx_par_n;
  logic                  tx_n, tx_ready_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      tx       <= tx_n;
      tx_ready <= tx_ready_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    case (tx_state)
      S_IDLE: if (tx_valid) begin
        tx_state_n = S_START;
        tx_cnt_n   = '0;
        tx_sh_n    = tx_data;
        tx_par_n   = calc_par(tx_data);
      end
      S_START: if (tx_cnt == BIT_LAST) begin
        tx_state_n = S_DATA;
        tx_cnt_n   = '0;
        tx_idx_n   = '0;
      end else tx_cnt_n = tx_cnt + CNT_W'(1);
      S_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        if (tx_idx == IDX_LAST) tx_state_n = HAS_PAR ? S_PAR : S_STOP;
        else begin
          tx_idx_n = tx_idx + IDX_W'(1);
          tx_sh_n  = tx_sh >> 1;
        end
      end else tx_cnt_n = tx_cnt + CNT_W'(1);
      S_PAR: if (tx_cnt == BIT_LAST) begin
        tx_state_n = S_STOP;
        tx_cnt_n   = '0;
      end else tx_cnt_n = tx_cnt + CNT_W'(1);
      S_STOP: if (tx_cnt == STOP_LAST) begin
        tx_state_n = S_IDLE;
        tx_cnt_n   = '0;
      end else tx_cnt_n = tx_cnt + CNT_W'(1);
      default: tx_state_n = S_IDLE;
    endcase
  end

  // Line level and ready are decoded from the next state so they register with it
  always_comb begin
    tx_n       = 1'b1;
    tx_ready_n = 1'b0;
    case (tx_state_n)
      S_IDLE:  tx_ready_n = 1'b1;
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = tx_sh_n[0];
      S_PAR:   tx_n = tx_par_n;
      default: tx_n = 1'b1;
    endcase
  end

  // ---------------- RX engine ----------------
  logic                  rx_s1, rx_s2;
  state_t                rx_state, rx_state_n;
  logic [CNT_W-1:0]      rx_cnt, rx_cnt_n;
  logic [IDX_W-1:0]      rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0]  rx_sh, rx_sh_n;
  logic                  rx_pbit, rx_pbit_n;
  logic                  done_c, par_err_c, frame_err_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_sh    <= rx_sh_n;
      rx_pbit  <= rx_pbit_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_sh_n    = rx_sh;
    rx_pbit_n  = rx_pbit;
    case (rx_state)
      S_IDLE: if (!rx_s2) begin
        rx_state_n = S_START;
        rx_cnt_n   = '0;
      end
      // Mid-start resample rejects short glitches
      S_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n   = '0;
        rx_idx_n   = '0;
        rx_state_n = rx_s2 ? S_IDLE : S_DATA;
      end else rx_cnt_n = rx_cnt + CNT_W'(1);
      S_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
        if (rx_idx == IDX_LAST) rx_state_n = HAS_PAR ? S_PAR : S_STOP;
        else rx_idx_n = rx_idx + IDX_W'(1);
      end else rx_cnt_n = rx_cnt + CNT_W'(1);
      S_PAR: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_pbit_n  = rx_s2;
        rx_state_n = S_STOP;
      end else rx_cnt_n = rx_cnt + CNT_W'(1);
      // Frame completes at mid-stop so the next start edge is never missed
      S_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_state_n = S_IDLE;
      end else rx_cnt_n = rx_cnt + CNT_W'(1);
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    done_c      = (rx_state == S_STOP) && (rx_cnt == BIT_LAST);
    par_err_c   = HAS_PAR && (rx_pbit != calc_par(rx_sh));
    frame_err_c = ~rx_s2;
  end

  // Single-entry holder: a completed frame is dropped only when the holder stays full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done_c) begin
      if (!rx_valid || rx_ready) begin
        rx_data    <= rx_sh;
        parity_err <= par_err_c;
        frame_err  <= frame_err_c;
        rx_valid   <= 1'b1;
        overrun    <= 1'b0;
      end else begin
        overrun    <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cfg_core.sv
// Bench for uart_cfg_core: three configurations (8N1, 7E2, 7O1) with loopback
// and model-driven RX, checked against a bit-level frame model.
`timescale 1ns/1ps
module tb_uart_cfg_core;
  localparam int unsigned CPB = 16;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         exp_par;
    logic [7:0] exp_rx;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] rx_pin, tx_o, txv, txr, rxr, rxv, pe, fe, ov, mdl_rx, loop_en;
  logic [7:0] txd [3];
  logic [7:0] rxd0;
  logic [6:0] rxd1, rxd2;
  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rx_pin = (loop_en & tx_o) | (~loop_en & mdl_rx);

  uart_cfg_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_pin[0]), .tx(tx_o[0]), .tx_data(txd[0]),
    .tx_valid(txv[0]), .tx_ready(txr[0]), .rx_data(rxd0), .rx_valid(rxv[0]),
    .rx_ready(rxr[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));
  uart_cfg_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_pin[1]), .tx(tx_o[1]), .tx_data(txd[1][6:0]),
    .tx_valid(txv[1]), .tx_ready(txr[1]), .rx_data(rxd1), .rx_valid(rxv[1]),
    .rx_ready(rxr[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));
  uart_cfg_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_pin[2]), .tx(tx_o[2]), .tx_data(txd[2][6:0]),
    .tx_valid(txv[2]), .tx_ready(txr[2]), .rx_data(rxd2), .rx_valid(rxv[2]),
    .rx_ready(rxr[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));

  function automatic int nb_of(input int i);   return (i == 0) ? 8 : 7; endfunction
  function automatic int stop_of(input int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int par_of(input int i);  return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic logic [7:0] mask_of(input int i); return (i == 0) ? 8'hFF : 8'h7F; endfunction

  function automatic logic [7:0] rxd_of(input int i);
    case (i)
      0:       return rxd0;
      1:       return {1'b0, rxd1};
      default: return {1'b0, rxd2};
    endcase
  endfunction

  // Line levels of one frame in transmission order; returns the bit count
  function automatic int build(input int i, input logic [7:0] d, input bit flip_par,
                               input bit stop_low, output logic [15:0] bits);
    int n;
    int ones;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int b = 0; b < nb_of(i); b++) begin bits[n] = d[b]; n++; end
    ones = $countones(d & mask_of(i));
    if (par_of(i) == 2) begin bits[n] = ones[0] ^ flip_par; n++; end
    else if (par_of(i) == 1) begin bits[n] = ~ones[0] ^ flip_par; n++; end
    for (int s = 0; s < stop_of(i); s++) begin bits[n] = !(stop_low && s == 0); n++; end
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, output int par_seen);
    logic [15:0] bits;
    int n, bad, waited, par_k;
    n = build(i, d & mask_of(i), 1'b0, 1'b0, bits);
    par_k = (1 + nb_of(i)) * int'(CPB) + int'(CPB) / 2;
    par_seen = -1; bad = 0; waited = 0;
    txd[i] = d & mask_of(i);
    txv[i] = 1'b1;
    while (txr[i] !== 1'b1 && waited < 4000) begin tick(1); waited++; end
    check($sformatf("tx_ready_wait[%0d]", i), 32'(txr[i]), 32'd1);
    if (txr[i] !== 1'b1) begin txv[i] = 1'b0; return; end
    tick(1);
    txv[i] = 1'b0;
    txd[i] = 8'($urandom);
    for (int k = 0; k < n * int'(CPB); k++) begin
      if (tx_o[i] !== bits[k / int'(CPB)] || txr[i] !== 1'b0) bad++;
      if (par_of(i) != 0 && k == par_k) par_seen = int'(tx_o[i]);
      tick(1);
    end
    check($sformatf("tx_wave[%0d] d=%0h bad_cycles", i, d), 32'(bad), 32'd0);
    check($sformatf("tx_idle[%0d]", i), 32'({txr[i], tx_o[i]}), 32'd3);
  endtask

  task automatic drive_rx(input int i, input logic [7:0] d, input bit flip_par, input bit stop_low);
    logic [15:0] bits;
    int n;
    n = build(i, d & mask_of(i), flip_par, stop_low, bits);
    loop_en[i] = 1'b0;
    for (int b = 0; b < n; b++) begin mdl_rx[i] = bits[b]; tick(CPB); end
    mdl_rx[i] = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic check_rx(input int i, input logic [7:0] d, input bit e_pe, input bit e_fe, input bit e_ov);
    check($sformatf("rx_valid[%0d]", i), 32'(rxv[i]), 32'd1);
    check($sformatf("rx_data[%0d]", i), 32'(rxd_of(i)), 32'(d));
    check($sformatf("parity_err[%0d]", i), 32'(pe[i]), 32'(e_pe));
    check($sformatf("frame_err[%0d]", i), 32'(fe[i]), 32'(e_fe));
    check($sformatf("overrun[%0d]", i), 32'(ov[i]), 32'(e_ov));
  endtask

  task automatic consume(input int i);
    rxr[i] = 1'b1;
    tick(1);
    rxr[i] = 1'b0;
    check($sformatf("rx_valid_clr[%0d]", i), 32'(rxv[i]), 32'd0);
    check($sformatf("overrun_clr[%0d]", i), 32'(ov[i]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    int   ps;
    int   idx;
    logic [7:0] d;
    bit   flip, sl;

    vecs[0] = '{0, 8'hA5, -1, 8'hA5};
    vecs[1] = '{1, 8'h07,  1, 8'h07};
    vecs[2] = '{2, 8'h07,  0, 8'h07};
    vecs[3] = '{0, 8'h00, -1, 8'h00};
    vecs[4] = '{0, 8'hFF, -1, 8'hFF};
    vecs[5] = '{1, 8'h7F,  1, 8'h7F};
    vecs[6] = '{2, 8'h7F,  0, 8'h7F};
    vecs[7] = '{2, 8'h3C,  1, 8'h3C};

    rst_n = 1'b0; txv = '0; rxr = '0; mdl_rx = '1; loop_en = '1;
    for (int i = 0; i < 3; i++) txd[i] = '0;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_tx[%0d]", i), 32'(tx_o[i]), 32'd1);
      check($sformatf("rst_tx_ready[%0d]", i), 32'(txr[i]), 32'd1);
      check($sformatf("rst_rx_valid[%0d]", i), 32'(rxv[i]), 32'd0);
      check($sformatf("rst_rx_data[%0d]", i), 32'(rxd_of(i)), 32'd0);
      check($sformatf("rst_flags[%0d]", i), 32'({pe[i], fe[i], ov[i]}), 32'd0);
    end
    rst_n = 1'b1;
    tick(2);

    // Loopback vectors with hand-computed parity bits
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].inst, vecs[v].data, ps);
      if (vecs[v].exp_par >= 0)
        check($sformatf("tx_parity_bit[%0d] d=%0h", vecs[v].inst, vecs[v].data), 32'(ps), 32'(vecs[v].exp_par));
      check_rx(vecs[v].inst, vecs[v].exp_rx, 1'b0, 1'b0, 1'b0);
      consume(vecs[v].inst);
    end

    // Corrupted parity, then low stop bit
    drive_rx(1, 8'h3C, 1'b1, 1'b0);
    check_rx(1, 8'h3C, 1'b1, 1'b0, 1'b0);
    consume(1);
    drive_rx(1, 8'h3C, 1'b0, 1'b1);
    check_rx(1, 8'h3C, 1'b0, 1'b1, 1'b0);
    consume(1);

    // Short low glitch must be ignored, then a clean frame
    loop_en[0] = 1'b0;
    mdl_rx[0] = 1'b0;
    tick(5);
    mdl_rx[0] = 1'b1;
    tick(3 * CPB);
    check("glitch_no_valid", 32'(rxv[0]), 32'd0);
    drive_rx(0, 8'h55, 1'b0, 1'b0);
    check_rx(0, 8'h55, 1'b0, 1'b0, 1'b0);
    consume(0);

    // Back-to-back frames into a full holder
    loop_en[0] = 1'b1;
    send(0, 8'h11, ps);
    send(0, 8'h22, ps);
    check_rx(0, 8'h11, 1'b0, 1'b0, 1'b1);
    consume(0);

    // Reset mid-frame on both engines
    loop_en[1:0] = 2'b11;
    txd[0] = 8'hF0; txd[1] = 8'h3C;
    txv[1:0] = 2'b11;
    tick(1);
    txv[1:0] = 2'b00;
    check("frame_started", 32'({txr[1:0], tx_o[1:0]}), 32'd0);
    tick(4 * CPB);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx", 32'(tx_o[1:0]), 32'd3);
    check("async_rst_tx_ready", 32'(txr[1:0]), 32'd3);
    check("async_rst_rx_valid", 32'(rxv[1:0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2 * CPB);
    check("post_rst_no_valid", 32'(rxv), 32'd0);
    send(0, 8'h81, ps);
    check_rx(0, 8'h81, 1'b0, 1'b0, 1'b0);
    consume(0);
    send(1, 8'h41, ps);
    check("post_rst_parity_bit", 32'(ps), 32'd0);
    check_rx(1, 8'h41, 1'b0, 1'b0, 1'b0);
    consume(1);

    // Randomized frames, loopback and model-driven with random corruption
    for (int r = 0; r < 30; r++) begin
      idx = int'($urandom_range(2, 0));
      d = 8'($urandom) & mask_of(idx);
      if (r % 3 != 0) begin
        loop_en[idx] = 1'b1;
        send(idx, d, ps);
        check_rx(idx, d, 1'b0, 1'b0, 1'b0);
      end else begin
        flip = 1'($urandom_range(1, 0));
        sl   = 1'($urandom_range(1, 0));
        drive_rx(idx, d, flip, sl);
        check_rx(idx, d, (par_of(idx) != 0) && flip, sl, 1'b0);
      end
      consume(idx);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
